// File: rtl/note_tone_if.sv
// Note-request / tone-output bundle between the keypad character source and
// the tone synthesizer.
interface note_tone_if #(
  parameter int PHASE_W = 32
);
  logic [7:0]         note_ascii1;
  logic [7:0]         note_ascii2;
  logic [7:0]         note_octave;
  logic               note_valid;
  logic               note_ready;
  logic               tone_en;
  logic [15:0]        tone_freq;
  logic [PHASE_W-1:0] phase_inc;
  logic               freq_valid;
  logic               note_err;
  logic               tone_out;

  modport master (
    output note_ascii1, note_ascii2, note_octave, note_valid, tone_en,
    input  note_ready, tone_freq, phase_inc, freq_valid, note_err, tone_out
  );

  modport slave (
    input  note_ascii1, note_ascii2, note_octave, note_valid, tone_en,
    output note_ready, tone_freq, phase_inc, freq_valid, note_err, tone_out
  );
endinterface

// File: rtl/note_tone_synth.sv
// ASCII note name -> equal-temperament frequency, NCO increment and square tone.
// Optional macro NOTE_FLAT_EN accepts 'b' as a flat accidental.
module note_tone_synth #(
  parameter int CLK_HZ  = 50000000,
  parameter int PHASE_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  note_tone_if.slave  nif
);

  // Increment per 1/16 Hz, scaled by 2^24 so the product keeps fractional bits.
  localparam logic [26:0] K =
    27'(((64'd1 << (PHASE_W + 20)) + 64'(CLK_HZ / 2)) / 64'(CLK_HZ));

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_ERR, S_MUL, S_LOAD} state_t;

  state_t             state;
  logic [7:0]         a1_q, a2_q, a3_q;
  logic               ready_q, freq_valid_q, note_err_q, tone_q;
  logic [15:0]        tone_freq_q;
  logic [PHASE_W-1:0] phase_inc_q, acc, acc_nxt;
  logic [17:0]        fq, mplier;
  logic [45:0]        mcand, prod;
  logic [4:0]         cnt;

  // Octave-9 pitch table in 1/16 Hz units, C..B.
  function automatic logic [17:0] q9_lut(input logic [3:0] s);
    case (s)
      4'd0:    q9_lut = 18'd133952;
      4'd1:    q9_lut = 18'd141918;
      4'd2:    q9_lut = 18'd150356;
      4'd3:    q9_lut = 18'd159297;
      4'd4:    q9_lut = 18'd168769;
      4'd5:    q9_lut = 18'd178805;
      4'd6:    q9_lut = 18'd189437;
      4'd7:    q9_lut = 18'd200702;
      4'd8:    q9_lut = 18'd212636;
      4'd9:    q9_lut = 18'd225280;
      4'd10:   q9_lut = 18'd238676;
      default: q9_lut = 18'd252868;
    endcase
  endfunction

  logic [3:0]  nat, semi, oct_lo;
  logic        dec_bad;
  logic [17:0] fq_dec;

  always_comb begin
    nat     = 4'd0;
    semi    = 4'd0;
    dec_bad = 1'b0;
    case (a1_q)
      "C":     nat = 4'd0;
      "D":     nat = 4'd2;
      "E":     nat = 4'd4;
      "F":     nat = 4'd5;
      "G":     nat = 4'd7;
      "A":     nat = 4'd9;
      "B":     nat = 4'd11;
      default: dec_bad = 1'b1;
    endcase
    case (a2_q)
      " ": semi = nat;
      "#": begin
        semi = nat + 4'd1;
        if (nat == 4'd4 || nat == 4'd11) dec_bad = 1'b1;
      end
`ifdef NOTE_FLAT_EN
      "b": begin
        semi = nat - 4'd1;
        if (nat == 4'd0 || nat == 4'd5) dec_bad = 1'b1;
      end
`endif
      default: dec_bad = 1'b1;
    endcase
    if (a3_q < "0" || a3_q > "9") dec_bad = 1'b1;
    oct_lo = 4'(a3_q - 8'h30);
    fq_dec = q9_lut(semi) >> (4'd9 - oct_lo);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      ready_q      <= 1'b0;
      freq_valid_q <= 1'b0;
      note_err_q   <= 1'b0;
      tone_freq_q  <= '0;
      phase_inc_q  <= '0;
      a1_q         <= '0;
      a2_q         <= '0;
      a3_q         <= '0;
      fq           <= '0;
      mplier       <= '0;
      mcand        <= '0;
      prod         <= '0;
      cnt          <= '0;
    end else begin
      freq_valid_q <= 1'b0;
      note_err_q   <= 1'b0;
      case (state)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (nif.note_valid && ready_q) begin
            a1_q    <= nif.note_ascii1;
            a2_q    <= nif.note_ascii2;
            a3_q    <= nif.note_octave;
            ready_q <= 1'b0;
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (dec_bad) begin
            note_err_q <= 1'b1;
            state      <= S_ERR;
          end else begin
            fq     <= fq_dec;
            mplier <= fq_dec;
            mcand  <= 46'(K);
            prod   <= '0;
            cnt    <= '0;
            state  <= S_MUL;
          end
        end
        S_ERR: begin
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end
        S_MUL: begin
          // One multiplier bit per cycle, LSB first.
          if (mplier[0]) prod <= prod + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          if (cnt == 5'd17) state <= S_LOAD;
        end
        S_LOAD: begin
          phase_inc_q  <= PHASE_W'(prod >> 24);
          tone_freq_q  <= 16'(({1'b0, fq} + 19'd8) >> 4);
          freq_valid_q <= 1'b1;
          ready_q      <= 1'b1;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Never cleared on a new note, so frequency changes stay phase-continuous.
  assign acc_nxt = acc + phase_inc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      tone_q <= 1'b0;
    end else if (nif.tone_en) begin
      acc    <= acc_nxt;
      tone_q <= acc_nxt[PHASE_W-1];
    end
  end

  assign nif.note_ready = ready_q;
  assign nif.tone_freq  = tone_freq_q;
  assign nif.phase_inc  = phase_inc_q;
  assign nif.freq_valid = freq_valid_q;
  assign nif.note_err   = note_err_q;
  assign nif.tone_out   = tone_q;

endmodule

// File: tb/tb_note_tone_synth.sv
// Bench for note_tone_synth: note table, randomized requests against a
// real-arithmetic pitch model, tone accumulator windows and mid-multiply reset.
module tb_note_tone_synth;
  localparam int PW = 32;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  longint kb;
  int   last_f;
  longint last_inc;
  logic [PW-1:0] acc_m;

  note_tone_if #(.PHASE_W(PW)) nif ();
  note_tone_synth #(.CLK_HZ(50000000), .PHASE_W(PW)) dut (
    .clk(clk), .reset(reset), .nif(nif.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Pitch computed directly from the equal-temperament formula.
  function automatic void model(input logic [7:0] a1, a2, a3,
                                output bit bad, output int f, output longint inc);
    int nat, s, oct, q9, fq;
    bad = 0; nat = -1; s = 0; f = 0; inc = 0;
    case (a1)
      "C": nat = 0;  "D": nat = 2;  "E": nat = 4;  "F": nat = 5;
      "G": nat = 7;  "A": nat = 9;  "B": nat = 11;
      default: nat = -1;
    endcase
    if (nat < 0) bad = 1;
    if (a2 == " ") s = nat;
    else if (a2 == "#") begin
      s = nat + 1;
      if (a1 == "E" || a1 == "B") bad = 1;
    end
`ifdef NOTE_FLAT_EN
    else if (a2 == "b") begin
      s = nat - 1;
      if (a1 == "C" || a1 == "F") bad = 1;
    end
`endif
    else bad = 1;
    if (a3 < "0" || a3 > "9") bad = 1;
    if (!bad) begin
      oct = int'(a3) - 48;
      q9  = $rtoi(225280.0 * (2.0 ** ((s - 9) / 12.0)) + 0.5);
      fq  = q9 >> (9 - oct);
      f   = (fq + 8) / 16;
      inc = ((longint'(fq) * kb) >> 24) & ((64'd1 << PW) - 1);
    end
  endfunction

  task automatic req(input logic [7:0] a1, a2, a3, input string nm,
                     output bit bad);
    int f; longint inc; int w;
    model(a1, a2, a3, bad, f, inc);
    w = 0;
    while (!nif.note_ready && w < 50) begin tick; w++; end
    chk({nm, "_ready_wait"}, nif.note_ready, 1);
    nif.note_ascii1 = a1; nif.note_ascii2 = a2; nif.note_octave = a3;
    nif.note_valid  = 1'b1;
    tick;
    nif.note_valid  = 1'b0;
    nif.note_ascii1 = 8'($urandom); nif.note_ascii2 = 8'($urandom);
    nif.note_octave = 8'($urandom);
    if (bad) begin
      for (int k = 1; k <= 3; k++) begin
        chk({nm, "_err"},   nif.note_err,   k == 2);
        chk({nm, "_ready"}, nif.note_ready, k == 3);
        chk({nm, "_fv"},    nif.freq_valid, 0);
        if (k < 3) tick;
      end
      chk({nm, "_freq_hold"}, nif.tone_freq, last_f);
      chk({nm, "_inc_hold"},  nif.phase_inc, last_inc);
    end else begin
      for (int k = 1; k <= 21; k++) begin
        chk({nm, "_ready"}, nif.note_ready, k == 21);
        chk({nm, "_fv"},    nif.freq_valid, k == 21);
        chk({nm, "_err"},   nif.note_err,   0);
        if (k == 20) chk({nm, "_freq_prev"}, nif.tone_freq, last_f);
        if (k < 21) tick;
      end
      chk({nm, "_freq"}, nif.tone_freq, f);
      chk({nm, "_inc"},  nif.phase_inc, inc);
      last_f = f; last_inc = inc;
    end
  endtask

  task automatic tone_run(input int n, input bit en, input string nm);
    int badc = 0;
    nif.tone_en = en;
    repeat (n) begin
      tick;
      if (en) acc_m = acc_m + PW'(last_inc);
      if (nif.tone_out !== acc_m[PW-1]) badc++;
    end
    nif.tone_en = 1'b0;
    chk({nm, "_tone_cycles_wrong"}, badc, 0);
  endtask

  typedef struct {
    logic [7:0] a1, a2, a3;
    bit         bad;
    int         f;
    longint     inc;
    bit         chk_inc;
  } vec_t;

  localparam int NT = 12;
  vec_t tbl[NT];
  logic [7:0] letters[10] = '{"A","B","C","D","E","F","G","H","a","@"};
  logic [7:0] accs[4]     = '{" ","#","b","!"};

  initial begin
    bit bad;
    kb = $rtoi((2.0 ** (PW + 20)) / 50000000.0 + 0.5);
    tbl[0]  = '{"A", " ", "4", 0, 440,   37795, 1};
    tbl[1]  = '{"C", " ", "4", 0, 262,   22473, 1};
    tbl[2]  = '{"C", " ", "0", 0, 16,    1401,  1};
    tbl[3]  = '{"B", " ", "9", 0, 15804, 0,     0};
    tbl[4]  = '{"E", "#", "4", 1, 0,     0,     0};
    tbl[5]  = '{"H", " ", "4", 1, 0,     0,     0};
    tbl[6]  = '{"A", " ", ":", 1, 0,     0,     0};
    tbl[7]  = '{"a", " ", "4", 1, 0,     0,     0};
    tbl[8]  = '{"C", "#", "4", 0, 277,   0,     0};
`ifdef NOTE_FLAT_EN
    tbl[9]  = '{"D", "b", "4", 0, 277,   0,     0};
`else
    tbl[9]  = '{"D", "b", "4", 1, 0,     0,     0};
`endif
    tbl[10] = '{"C", "b", "4", 1, 0,     0,     0};
    tbl[11] = '{"B", "#", "9", 1, 0,     0,     0};

    nif.note_ascii1 = " "; nif.note_ascii2 = " "; nif.note_octave = " ";
    nif.note_valid = 1'b0; nif.tone_en = 1'b0;
    reset = 1'b1; last_f = 0; last_inc = 0; acc_m = '0;
    repeat (3) tick;
    chk("rst_ready", nif.note_ready, 0);
    chk("rst_freq",  nif.tone_freq,  0);
    chk("rst_inc",   nif.phase_inc,  0);
    chk("rst_fv",    nif.freq_valid, 0);
    chk("rst_err",   nif.note_err,   0);
    chk("rst_tone",  nif.tone_out,   0);
    reset = 1'b0;
    tick;
    chk("post_rst_ready", nif.note_ready, 1);

    for (int i = 0; i < NT; i++) begin
      req(tbl[i].a1, tbl[i].a2, tbl[i].a3, $sformatf("tbl%0d", i), bad);
      chk($sformatf("tbl%0d_bad", i), bad, tbl[i].bad);
      if (!tbl[i].bad) begin
        chk($sformatf("tbl%0d_freq_const", i), nif.tone_freq, tbl[i].f);
        if (tbl[i].chk_inc)
          chk($sformatf("tbl%0d_inc_const", i), nif.phase_inc, tbl[i].inc);
      end
    end

    req("B", " ", "9", "toneB9", bad);
    tone_run(7000, 1, "b9_run");
    tone_run(50,   0, "b9_freeze");
    tone_run(4000, 1, "b9_resume");
    req("A", " ", "4", "toneA4", bad);
    tone_run(20000, 1, "a4_cont");

    for (int i = 0; i < 40; i++) begin
      logic [7:0] a1, a2, a3;
      a1 = letters[$urandom_range(9, 0)];
      a2 = accs[$urandom_range(3, 0)];
      a3 = 8'($urandom_range(8'h3a, 8'h2f));
      req(a1, a2, a3, $sformatf("rnd%0d", i), bad);
    end

    // Reset in the middle of a multiply.
    req("G", " ", "9", "pre_rst", bad);
    tone_run(300, 1, "pre_rst_run");
    while (!nif.note_ready) tick;
    nif.note_ascii1 = "A"; nif.note_ascii2 = " "; nif.note_octave = "4";
    nif.note_valid = 1'b1;
    tick;
    nif.note_valid = 1'b0;
    repeat (10) tick;
    reset = 1'b1;
    tick;
    chk("mrst_ready", nif.note_ready, 0);
    chk("mrst_freq",  nif.tone_freq,  0);
    chk("mrst_inc",   nif.phase_inc,  0);
    chk("mrst_fv",    nif.freq_valid, 0);
    chk("mrst_err",   nif.note_err,   0);
    chk("mrst_tone",  nif.tone_out,   0);
    tick;
    chk("mrst_fv_late", nif.freq_valid, 0);
    reset = 1'b0; acc_m = '0; last_f = 0; last_inc = 0;
    tick;
    chk("mrst_ready_after", nif.note_ready, 1);
    req("A", " ", "4", "post_rst", bad);
    tone_run(500, 1, "post_rst_run");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
